// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg
//   Shared definitions for the push-button conditioning front end:
//   per-channel FSM state encoding, default cycle counts (50 MHz board clock)
//   and the counter-width helper used by every channel.
package key_debouncer_pkg;

   typedef enum logic [2:0] {
      RELEASED,
      PRESS_CHK,
      HELD,
      REPEATING,
      RELEASE_CHK
   } key_fsm_e;

   localparam int unsigned DEF_NKEYS             = 3;
   localparam int unsigned DEF_DEBOUNCE_CYC      = 250000;    // 5 ms
   localparam int unsigned DEF_REPEAT_DELAY_CYC  = 25000000;  // 500 ms
   localparam int unsigned DEF_REPEAT_PERIOD_CYC = 5000000;   // 100 ms
   localparam int unsigned DEF_REPEAT_EN         = 1;

   // Width that holds (largest terminal count - 1); never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch
//   One key channel: 2-flop synchroniser, debounce/auto-repeat FSM and its
//   shared cycle counter. All outputs are registered.
// Ports:
//   clk          system clock
//   rst_key      asynchronous active-low reset
//   key_raw      raw asynchronous key, active-low
//   key_state    debounced level, 1 = held
//   key_press    one-cycle strobe on accepted press
//   key_release  one-cycle strobe on accepted release
//   key_repeat   one-cycle auto-repeat strobe while held
module key_debounce_ch
   import key_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
   parameter int unsigned REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
   parameter int unsigned REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
   parameter int unsigned REPEAT_EN         = DEF_REPEAT_EN
) (
   input  logic clk,
   input  logic rst_key,
   input  logic key_raw,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_repeat
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY_CYC - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD_CYC - 1);

   logic [1:0]    sync_q;
   logic          sync;
   key_fsm_e      st;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   assign sync = sync_q[1];

   // Saturating increment: with repeat disabled HELD counts indefinitely.
   always_comb begin
      cnt_inc = cnt;
      if (cnt != '1) cnt_inc = cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_key) begin
      if (!rst_key) begin
         sync_q      <= '1;
         st          <= RELEASED;
         cnt         <= '0;
         key_state   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_repeat  <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], key_raw};
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_repeat  <= 1'b0;
         unique case (st)
            RELEASED: begin
               if (!sync) begin
                  st  <= PRESS_CHK;
                  cnt <= '0;
               end
            end
            PRESS_CHK: begin
               if (sync) begin
                  st  <= RELEASED;
                  cnt <= '0;
               end else if (cnt == DEB_LAST) begin
                  st        <= HELD;
                  key_press <= 1'b1;
                  key_state <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            HELD: begin
               if (sync) begin
                  st  <= RELEASE_CHK;
                  cnt <= '0;
               end else if ((REPEAT_EN != 0) && (cnt == DLY_LAST)) begin
                  st         <= REPEATING;
                  key_repeat <= 1'b1;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            REPEATING: begin
               if (sync) begin
                  st  <= RELEASE_CHK;
                  cnt <= '0;
               end else if (cnt == PER_LAST) begin
                  key_repeat <= 1'b1;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            RELEASE_CHK: begin
               // Returning to HELD (not REPEATING) restarts the repeat delay.
               if (!sync) begin
                  st  <= HELD;
                  cnt <= '0;
               end else if (cnt == DEB_LAST) begin
                  st          <= RELEASED;
                  key_release <= 1'b1;
                  key_state   <= 1'b0;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               st  <= RELEASED;
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer
//   Conditions NKEYS raw active-low push-buttons into debounced levels and
//   one-cycle press / release / auto-repeat strobes. Channels are independent.
// Ports:
//   clk          system clock
//   rst_key      asynchronous active-low reset
//   keys         raw asynchronous keys, active-low (0 = pressed)
//   key_state    debounced level, active-high
//   key_press    one-cycle strobe per accepted press
//   key_release  one-cycle strobe per accepted release
//   key_repeat   one-cycle auto-repeat strobe while held
module key_debouncer
   import key_debouncer_pkg::*;
#(
   parameter int unsigned NKEYS             = DEF_NKEYS,
   parameter int unsigned DEBOUNCE_CYC      = DEF_DEBOUNCE_CYC,
   parameter int unsigned REPEAT_DELAY_CYC  = DEF_REPEAT_DELAY_CYC,
   parameter int unsigned REPEAT_PERIOD_CYC = DEF_REPEAT_PERIOD_CYC,
   parameter int unsigned REPEAT_EN         = DEF_REPEAT_EN
) (
   input  logic             clk,
   input  logic             rst_key,
   input  logic [NKEYS-1:0] keys,
   output logic [NKEYS-1:0] key_state,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release,
   output logic [NKEYS-1:0] key_repeat
);

   for (genvar i = 0; i < NKEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYC      (DEBOUNCE_CYC),
         .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
         .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC),
         .REPEAT_EN         (REPEAT_EN)
      ) u_ch (
         .clk         (clk),
         .rst_key     (rst_key),
         .key_raw     (keys[i]),
         .key_state   (key_state[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_repeat  (key_repeat[i])
      );
   end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
//   Directed stimulus for key_debouncer (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10,
//   REPEAT_PERIOD_CYC=3). The stimulus process schedules expected events by
//   absolute cycle number; a monitor pops one whenever a strobe appears or a
//   scheduled state-only check falls due.
module tb_key_debouncer;

   logic       clk = 1'b0;
   logic       rst_key;
   logic [2:0] keys;
   logic [2:0] key_state, key_press, key_release, key_repeat;

   key_debouncer #(
      .NKEYS             (3),
      .DEBOUNCE_CYC      (4),
      .REPEAT_DELAY_CYC  (10),
      .REPEAT_PERIOD_CYC (3),
      .REPEAT_EN         (1)
   ) dut (
      .clk         (clk),
      .rst_key     (rst_key),
      .keys        (keys),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_repeat  (key_repeat)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; read at falling edges.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [2:0] p;
      logic [2:0] r;
      logic [2:0] rp;
      logic [2:0] st;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   bit   mon_en = 1'b0;

   task automatic push(input int c, input logic [2:0] p, input logic [2:0] r,
                       input logic [2:0] rp, input logic [2:0] st, input string tag);
      exp_t e;
      e.c = c; e.p = p; e.r = r; e.rp = rp; e.st = st; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic waitc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if ((|{key_press, key_release, key_repeat}) || (sb.size() > 0 && sb[0].c == cyc)) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_strobe cyc=%0d: got press=%b release=%b repeat=%b state=%b, expected no strobe",
                        cyc, key_press, key_release, key_repeat, key_state);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (e.c != cyc || key_press !== e.p || key_release !== e.r ||
                   key_repeat !== e.rp || key_state !== e.st) begin
                  n_bad++;
                  $display("FAIL %s: got cyc=%0d press=%b release=%b repeat=%b state=%b, expected cyc=%0d press=%b release=%b repeat=%b state=%b",
                           e.tag, cyc, key_press, key_release, key_repeat, key_state,
                           e.c, e.p, e.r, e.rp, e.st);
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      int t;
      rst_key = 1'b1;
      keys    = 3'b111;
      #1 rst_key = 1'b0;
      mon_en = 1'b1;

      // Reset state
      waitc(2);
      push(cyc + 1, 3'b000, 3'b000, 3'b000, 3'b000, "reset_state");
      waitc(2);
      rst_key = 1'b1;
      waitc(3);

      // Press latency, release glitch restarting repeat delay, repeat, release (key 0)
      t = cyc;
      push(t + 6,  3'b000, 3'b000, 3'b000, 3'b000, "pre_press_k0");
      push(t + 7,  3'b001, 3'b000, 3'b000, 3'b001, "press_k0");
      push(t + 8,  3'b000, 3'b000, 3'b000, 3'b001, "held_k0");
      push(t + 14, 3'b000, 3'b000, 3'b000, 3'b001, "glitch_hold_k0");
      push(t + 25, 3'b000, 3'b000, 3'b001, 3'b001, "repeat1_k0");
      push(t + 28, 3'b000, 3'b000, 3'b001, 3'b001, "repeat2_k0");
      push(t + 34, 3'b000, 3'b000, 3'b000, 3'b001, "relchk_k0");
      push(t + 35, 3'b000, 3'b001, 3'b000, 3'b000, "release_k0");
      keys[0] = 1'b0;
      waitc(10);
      keys[0] = 1'b1;
      waitc(2);
      keys[0] = 1'b0;
      waitc(16);
      keys[0] = 1'b1;
      waitc(10);

      // Bounce rejection (key 1)
      t = cyc;
      push(t + 6,  3'b000, 3'b000, 3'b000, 3'b000, "bounce_a");
      push(t + 12, 3'b000, 3'b000, 3'b000, 3'b000, "bounce_b");
      push(t + 14, 3'b000, 3'b000, 3'b000, 3'b000, "bounce_c");
      keys[1] = 1'b0;
      waitc(3);
      keys[1] = 1'b1;
      waitc(2);
      keys[1] = 1'b0;
      waitc(3);
      keys[1] = 1'b1;
      waitc(8);

      // Auto-repeat over a 40-cycle hold (key 2)
      t = cyc;
      push(t + 7, 3'b100, 3'b000, 3'b000, 3'b100, "press_k2");
      for (int k = 0; k < 9; k++)
         push(t + 17 + 3 * k, 3'b000, 3'b000, 3'b100, 3'b100, $sformatf("repeat%0d_k2", k));
      push(t + 46, 3'b000, 3'b000, 3'b000, 3'b100, "relchk_k2");
      push(t + 47, 3'b000, 3'b100, 3'b000, 3'b000, "release_k2");
      keys[2] = 1'b0;
      waitc(40);
      keys[2] = 1'b1;
      waitc(10);

      // Simultaneous press / release
      t = cyc;
      push(t + 7,  3'b111, 3'b000, 3'b000, 3'b111, "press_all");
      push(t + 17, 3'b000, 3'b111, 3'b000, 3'b000, "release_all");
      keys = 3'b000;
      waitc(10);
      keys = 3'b111;
      waitc(10);

      // Reset while key 0 held and key 1 in press check
      t = cyc;
      push(t + 7,  3'b001, 3'b000, 3'b000, 3'b001, "press_k0_prerst");
      push(t + 8,  3'b000, 3'b000, 3'b000, 3'b001, "held_k0_prerst");
      push(t + 13, 3'b000, 3'b000, 3'b000, 3'b000, "in_reset");
      push(t + 21, 3'b011, 3'b000, 3'b000, 3'b011, "press_postrst");
      push(t + 30, 3'b000, 3'b011, 3'b000, 3'b000, "release_postrst");
      keys[0] = 1'b0;
      waitc(8);
      keys[1] = 1'b0;
      waitc(4);
      #1 rst_key = 1'b0;
      waitc(2);
      rst_key = 1'b1;
      waitc(9);
      keys = 3'b111;
      waitc(12);

      // Anything still queued never appeared
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no event by cyc=%0d, expected cyc=%0d press=%b release=%b repeat=%b state=%b",
                  e.tag, cyc, e.c, e.p, e.r, e.rp, e.st);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
